// File: rtl/v810_cache_fill_pkg.sv
// v810_cache_pkg: shared fill-state type and line sizing helpers for the V810 I-cache.
package v810_cache_pkg;
   typedef enum logic {FILL_IDLE, FILL_FETCH} fill_state_e;
   localparam int LINE_WORDS = 2;
   function automatic int off_w(input int words);
      return (words > 1) ? $clog2(words) : 1;
   endfunction
   localparam int OFF_W = off_w(LINE_WORDS);
endpackage

// File: rtl/v810_cache_fill_if.sv
// v810_cache_fill_if: read-beat bus between the line-fill engine and the memory side.
interface v810_cache_fill_if;
   logic        bus_req;
   logic [29:0] bus_addr;
   logic        bus_ack;
   logic        bus_err;
   logic [31:0] bus_rdata;
   modport master (output bus_req, bus_addr, input bus_ack, bus_err, bus_rdata);
   modport slave  (input bus_req, bus_addr, output bus_ack, bus_err, bus_rdata);
endinterface

// File: rtl/v810_cache_fill.sv
// v810_cache_fill: I-cache line fill, critical word first with wrap-around inside the line.
module v810_cache_fill
   import v810_cache_pkg::*;
#(
   parameter int addr_width = 8,
   parameter int line_words = LINE_WORDS
) (
   input  logic                                    clock,
   input  logic                                    reset,
   input  logic                                    fill_req,
   input  logic [29:0]                             fill_addr,
   input  logic [addr_width-off_w(line_words)-1:0] fill_line,
   output logic                                    fill_busy,
   output logic                                    fill_done,
   output logic                                    fill_err,
   output logic                                    crit_valid,
   output logic [31:0]                             crit_data,
   v810_cache_fill_if.master                       bus,
   output logic                                    ram_wr_en,
   output logic [addr_width-1:0]                   ram_wr_address,
   output logic [31:0]                             ram_wr_data
);
   localparam int ow = off_w(line_words);
   localparam int lw_w = addr_width - ow;
   localparam logic [ow:0] cnt_last = (ow+1)'(line_words - 1);
   fill_state_e state_q, state_d;
   logic [ow:0] cnt_q, cnt_d;
   logic [ow-1:0] base_q, base_d, off, off_nx;
   logic [lw_w-1:0] line_q, line_d;
   logic busy_q, busy_d, done_q, done_d, err_q, err_d;
   logic crit_valid_q, crit_valid_d, req_q, req_d, wr_en_q, wr_en_d;
   logic [29:0] addr_q, addr_d;
   logic [31:0] crit_data_q, crit_data_d, wr_data_q, wr_data_d;
   logic [addr_width-1:0] wr_addr_q, wr_addr_d;
   always_comb begin
      state_d = state_q;
      cnt_d = cnt_q;
      base_d = base_q;
      line_d = line_q;
      busy_d = busy_q;
      req_d = req_q;
      done_d = 1'b0;
      err_d = 1'b0;
      crit_valid_d = 1'b0;
      wr_en_d = 1'b0;
      addr_d = addr_q;
      crit_data_d = crit_data_q;
      wr_data_d = wr_data_q;
      wr_addr_d = wr_addr_q;
      // only the offset bits wrap; the upper address bits stay as latched
      off = base_q + cnt_q[ow-1:0];
      off_nx = off + ow'(1);
      if (state_q == FILL_IDLE) begin
         if (fill_req) begin
            state_d = FILL_FETCH;
            base_d = fill_addr[ow-1:0];
            line_d = fill_line;
            cnt_d = '0;
            busy_d = 1'b1;
            req_d = 1'b1;
            addr_d = fill_addr;
         end
      end else if (bus.bus_err) begin
         state_d = FILL_IDLE;
         busy_d = 1'b0;
         req_d = 1'b0;
         err_d = 1'b1;
      end else if (bus.bus_ack) begin
         wr_en_d = 1'b1;
         wr_addr_d = {line_q, off};
         wr_data_d = bus.bus_rdata;
         addr_d = {addr_q[29:ow], off_nx};
         cnt_d = cnt_q + (ow+1)'(1);
         crit_valid_d = (cnt_q == '0);
         crit_data_d = (cnt_q == '0) ? bus.bus_rdata : crit_data_q;
         if (cnt_q == cnt_last) begin
            state_d = FILL_IDLE;
            busy_d = 1'b0;
            req_d = 1'b0;
            done_d = 1'b1;
         end
      end
   end
   always_ff @(posedge clock) begin
      if (reset) begin
         state_q <= FILL_IDLE;
         cnt_q <= '0;
         base_q <= '0;
         line_q <= '0;
         busy_q <= 1'b0;
         done_q <= 1'b0;
         err_q <= 1'b0;
         crit_valid_q <= 1'b0;
         req_q <= 1'b0;
         wr_en_q <= 1'b0;
         addr_q <= '0;
         crit_data_q <= '0;
         wr_data_q <= '0;
         wr_addr_q <= '0;
      end else begin
         state_q <= state_d;
         cnt_q <= cnt_d;
         base_q <= base_d;
         line_q <= line_d;
         busy_q <= busy_d;
         done_q <= done_d;
         err_q <= err_d;
         crit_valid_q <= crit_valid_d;
         req_q <= req_d;
         wr_en_q <= wr_en_d;
         addr_q <= addr_d;
         crit_data_q <= crit_data_d;
         wr_data_q <= wr_data_d;
         wr_addr_q <= wr_addr_d;
      end
   end
   assign fill_busy = busy_q;
   assign fill_done = done_q;
   assign fill_err = err_q;
   assign crit_valid = crit_valid_q;
   assign crit_data = crit_data_q;
   assign bus.bus_req = req_q;
   assign bus.bus_addr = addr_q;
   assign ram_wr_en = wr_en_q;
   assign ram_wr_address = wr_addr_q;
   assign ram_wr_data = wr_data_q;
endmodule
